// File: rtl/cpu_clk_ctrl_if.sv
// Bus between the run/step/halt controller and the logic around it:
// the slow clock, the operator controls, the CPU halt flag and the
// clock-enable and status outputs.
interface cpu_clk_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             dclk;
    logic             run_sw;
    logic             step_btn;
    logic             hlt;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output dclk, run_sw, step_btn, hlt,
        input  cpu_en, running, halted, cycle_cnt
    );

    modport slave (
        input  dclk, run_sw, step_btn, hlt,
        output cpu_en, running, halted, cycle_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller for the 8-bit processor. Each rising edge of
// the slow clock dclk becomes a single-cycle cpu_en pulse, gated by the
// run switch, a debounced single-step button and the CPU halt flag.
// The number of pulses issued is counted in a wrapping counter.
module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst,
    cpu_clk_ctrl_if.slave  bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        run_sync;
    logic [1:0]        step_sync;
    logic              dclk_q;
    logic [DB_W-1:0]   db_cnt;
    logic              step_db;
    logic              step_db_q;
    logic              cpu_en_r;
    logic              running_r;
    logic              halted_r;
    logic [CNT_W-1:0]  cnt_r;

    logic run_s;
    logic step_s;
    logic tick;
    logic step_req;

    assign run_s    = run_sync[1];
    assign step_s   = step_sync[1];
    assign tick     = bus.dclk & ~dclk_q;
    assign step_req = step_db & ~step_db_q;

    assign bus.cpu_en    = cpu_en_r;
    assign bus.running   = running_r;
    assign bus.halted    = halted_r;
    assign bus.cycle_cnt = cnt_r;

    // Synchronise the operator inputs and remember last dclk; dclk_q resets
    // high so a dclk already high at reset release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_sync  <= 2'b00;
            step_sync <= 2'b00;
            dclk_q    <= 1'b1;
        end else begin
            run_sync  <= {run_sync[0], bus.run_sw};
            step_sync <= {step_sync[0], bus.step_btn};
            dclk_q    <= bus.dclk;
        end
    end

    // Accept a new button level only after it has differed from the current
    // accepted level for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            step_db   <= 1'b0;
            step_db_q <= 1'b0;
        end else begin
            step_db_q <= step_db;
            if (step_s == step_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                step_db <= step_s;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Mode FSM with registered pulse, status flags and pulse counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_en_r  <= 1'b0;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
            cnt_r     <= '0;
        end else begin
            cpu_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hlt) begin
                        state    <= HALTED;
                        halted_r <= 1'b1;
                    end else if (run_s) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end else if (step_req) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    if (bus.hlt) begin
                        state     <= HALTED;
                        running_r <= 1'b0;
                        halted_r  <= 1'b1;
                    end else if (!run_s) begin
                        state     <= IDLE;
                        running_r <= 1'b0;
                    end else if (tick) begin
                        cpu_en_r <= 1'b1;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                STEP: begin
                    if (bus.hlt) begin
                        state    <= HALTED;
                        halted_r <= 1'b1;
                    end else if (tick) begin
                        cpu_en_r <= 1'b1;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios followed by a
// randomised phase, all compared cycle by cycle against a behavioural
// model built from delay lines and a debounce run-length counter.
module tb_cpu_clk_ctrl;
    localparam int DB = 4;
    localparam int CW = 4;

    typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

    logic clk = 1'b0;
    logic rst;

    cpu_clk_ctrl_if #(.CNT_W(CW)) bus ();

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    mode_t mode;
    bit    m_en;
    int    m_cnt;
    bit    run_d[2];
    bit    btn_d[2];
    bit    prev_dclk;
    bit    db_level;
    bit    db_prev;
    int    db_run;

    int phase;
    int edge_phase;
    int checks;
    int errors;
    int pulses;
    int last_pulse_phase;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelEdge(input bit r, input bit run_v, input bit btn_v, input bit hlt_v, input bit dclk_v);
        bit run_s;
        bit btn_s;
        bit tick;
        bit step_req;
        if (r) begin
            mode      = M_IDLE;
            m_en      = 0;
            m_cnt     = 0;
            run_d[0]  = 0;
            run_d[1]  = 0;
            btn_d[0]  = 0;
            btn_d[1]  = 0;
            prev_dclk = 1;
            db_level  = 0;
            db_prev   = 0;
            db_run    = 0;
            return;
        end
        run_s    = run_d[1];
        btn_s    = btn_d[1];
        tick     = dclk_v && !prev_dclk;
        step_req = db_level && !db_prev;
        m_en     = 0;
        case (mode)
            M_IDLE: begin
                if (hlt_v) mode = M_HALT;
                else if (run_s) mode = M_RUN;
                else if (step_req) mode = M_STEP;
            end
            M_RUN: begin
                if (hlt_v) mode = M_HALT;
                else if (!run_s) mode = M_IDLE;
                else if (tick) begin
                    m_en  = 1;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
            end
            M_STEP: begin
                if (hlt_v) mode = M_HALT;
                else if (tick) begin
                    m_en  = 1;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    mode  = M_IDLE;
                end
            end
            default: ;
        endcase
        db_prev = db_level;
        if (btn_s == db_level) begin
            db_run = 0;
        end else begin
            db_run++;
            if (db_run == DB) begin
                db_level = btn_s;
                db_run   = 0;
            end
        end
        run_d[1]  = run_d[0];
        run_d[0]  = run_v;
        btn_d[1]  = btn_d[0];
        btn_d[0]  = btn_v;
        prev_dclk = dclk_v;
    endtask

    task automatic applyStimulus(input bit r, input bit run_v, input bit btn_v, input bit hlt_v);
        bit dclk_v;
        @(negedge clk);
        dclk_v       = (phase >= 2);
        rst          = r;
        bus.run_sw   = run_v;
        bus.step_btn = btn_v;
        bus.hlt      = hlt_v;
        bus.dclk     = dclk_v;
        @(posedge clk);
        modelEdge(r, run_v, btn_v, hlt_v, dclk_v);
        edge_phase = phase;
        phase      = (phase + 1) % 10;
        #1;
        checkOutput("cpu_en", bus.cpu_en, m_en);
        checkOutput("running", bus.running, (mode == M_RUN));
        checkOutput("halted", bus.halted, (mode == M_HALT));
        checkOutput("cycle_cnt", bus.cycle_cnt, m_cnt);
        if (bus.cpu_en === 1'b1) begin
            pulses++;
            last_pulse_phase = edge_phase;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int c0;
        int rises;
        int first_phase;
        int halt_wait;
        bit run_v;
        bit btn_v;
        bit r;
        bit h;

        checks = 0;
        errors = 0;
        pulses = 0;
        phase  = 0;
        last_pulse_phase = -1;

        // Reset state
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkOutput("rst_cpu_en", bus.cpu_en, 0);
        checkOutput("rst_cnt", bus.cycle_cnt, 0);

        // Free run
        repeat (3) applyStimulus(0, 1, 0, 0);
        p0    = pulses;
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            if (phase == 2) rises++;
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("free_pulses", pulses - p0, rises);
        checkOutput("free_running", bus.running, 1);
        checkOutput("free_cnt", bus.cycle_cnt, pulses % 16);

        // Stop on a tick: run_s falls on the edge that sees the dclk rise
        for (int i = 0; i < 10 && phase != 0; i++) applyStimulus(0, 1, 0, 0);
        c0 = bus.cycle_cnt;
        p0 = pulses;
        repeat (6) applyStimulus(0, 0, 0, 0);
        checkOutput("stop_pulses", pulses - p0, 0);
        checkOutput("stop_running", bus.running, 0);
        checkOutput("stop_cnt", bus.cycle_cnt, c0);

        // Single step with bounce
        repeat (10) applyStimulus(0, 0, 0, 0);
        p0 = pulses;
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        repeat (71) applyStimulus(0, 0, 1, 0);
        checkOutput("step_pulses", pulses - p0, 1);
        checkOutput("step_running", bus.running, 0);
        repeat (10) applyStimulus(0, 0, 0, 0);

        // Halt coinciding with a tick
        repeat (5) applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 10 && phase != 2; i++) applyStimulus(0, 1, 0, 0);
        p0 = pulses;
        applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 40; i++) applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        checkOutput("halt_pulses", pulses - p0, 0);
        checkOutput("halt_flag", bus.halted, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("halt_rst_flag", bus.halted, 0);
        checkOutput("halt_rst_running", bus.running, 0);

        // Wrap of the pulse counter
        p0 = pulses;
        repeat (185) applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_enough", ((pulses - p0) >= 17), 1);
        checkOutput("wrap_cnt", bus.cycle_cnt, (pulses - p0) % 16);

        // Reset while dclk high
        for (int i = 0; i < 10 && phase != 5; i++) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        p0 = pulses;
        first_phase = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1, 0, 0);
            if (pulses > p0 && first_phase < 0) first_phase = last_pulse_phase;
        end
        checkOutput("rsthi_first_phase", first_phase, 2);
        checkOutput("rsthi_pulses", pulses - p0, 3);

        // Randomised operation
        run_v     = 0;
        btn_v     = 0;
        halt_wait = 0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            r = 0;
            if (halt_wait > 0) begin
                halt_wait--;
                if (halt_wait == 0) r = 1;
            end
            if ($urandom_range(0, 39) == 0) run_v = ~run_v;
            if ($urandom_range(0, 9) == 0) btn_v = ~btn_v;
            h = (halt_wait == 0) && ($urandom_range(0, 299) == 0);
            if (h) halt_wait = 20;
            applyStimulus(r, run_v, btn_v, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
